// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending controller.
// Accumulates coin credit in 5-rupee units, sells NUM_PRODUCTS products at packed per-product
// prices, keeps a stock counter per product, and pays change one unit at a time to the hopper
// over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   coin_valid_i/coin_i coin strobe and value (01=1 unit, 10=2, 11=3, 00=invalid)
//   sel_valid_i/sel_id_i product-select strobe and product index
//   cancel_i            refund request
//   restock_i           reload every stock counter to STOCK_INIT
//   change_ready_i      hopper accepts one change unit this cycle
//   credit_o            current credit in units
//   dispense_o/dispense_id_o  one-cycle release pulse and product index
//   coin_reject_o       one-cycle pulse, coin returned
//   sel_reject_o        one-cycle pulse, selection refused
//   change_valid_o      one change unit offered
//   busy_o              high while dispensing or paying change
//   sold_out_o          bit i set when product i has no stock
module vending_machine_multi #(
    parameter int unsigned NUM_PRODUCTS = 4,
    parameter int unsigned PRICE_W      = 4,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES = {4'd4, 4'd3, 4'd2, 4'd3},
    parameter int unsigned CREDIT_W     = 6,
    parameter int unsigned MAX_CREDIT   = 20,
    parameter int unsigned STOCK_W      = 4,
    parameter int unsigned STOCK_INIT   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coin_valid_i,
    input  logic [1:0]              coin_i,
    input  logic                    sel_valid_i,
    input  logic [2:0]              sel_id_i,
    input  logic                    cancel_i,
    input  logic                    restock_i,
    input  logic                    change_ready_i,
    output logic [CREDIT_W-1:0]     credit_o,
    output logic                    dispense_o,
    output logic [2:0]              dispense_id_o,
    output logic                    coin_reject_o,
    output logic                    sel_reject_o,
    output logic                    change_valid_o,
    output logic                    busy_o,
    output logic [NUM_PRODUCTS-1:0] sold_out_o
);

    localparam logic [CREDIT_W:0]  MaxCreditExt = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0] StockInit    = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {StCollect, StDispense, StChange} state_e;

    state_e               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [CREDIT_W-1:0]  change_left_q, change_left_d;
    logic [STOCK_W-1:0]   stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0]   stock_d [NUM_PRODUCTS];
    logic [2:0]           disp_id_q, disp_id_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_reject_q, sel_reject_d;

    // Product lookup. An out-of-range index matches no product and so looks empty,
    // which folds the range check into the stock check.
    logic [NUM_PRODUCTS-1:0] sel_hit;
    logic [PRICE_W-1:0]      sel_price;
    logic                    sel_empty;
    logic                    sel_ok;
    logic [CREDIT_W:0]       coin_sum;

    always_comb begin
        sel_hit   = '0;
        sel_price = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel_id_i == 3'(i)) begin
                sel_hit[i] = 1'b1;
                sel_price  = PRICES[i*PRICE_W +: PRICE_W];
                sel_empty  = (stock_q[i] == '0);
            end
        end
        sel_ok   = !sel_empty && (credit_q >= CREDIT_W'(sel_price));
        // One extra bit so a sum near the top of the counter cannot wrap past the ceiling.
        coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_i);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StCollect;
        else        state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q      <= '0;
            change_left_q <= '0;
            disp_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_reject_q  <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= StockInit;
        end else begin
            credit_q      <= credit_d;
            change_left_q <= change_left_d;
            disp_id_q     <= disp_id_d;
            coin_reject_q <= coin_reject_d;
            sel_reject_q  <= sel_reject_d;
            for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= stock_d[i];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_left_d = change_left_q;
        disp_id_d     = disp_id_q;
        coin_reject_d = 1'b0;
        sel_reject_d  = 1'b0;
        stock_d       = stock_q;
        unique case (state_q)
            StCollect: begin
                if (restock_i) begin
                    for (int i = 0; i < NUM_PRODUCTS; i++) stock_d[i] = StockInit;
                end
                if (cancel_i) begin
                    coin_reject_d = coin_valid_i;
                    if (credit_q != '0) begin
                        change_left_d = credit_q;
                        credit_d      = '0;
                        state_d       = StChange;
                    end
                end else if (sel_valid_i) begin
                    coin_reject_d = coin_valid_i;
                    if (!sel_ok) begin
                        sel_reject_d = 1'b1;
                    end else begin
                        // Decrement on top of a same-cycle restock so neither event is lost.
                        for (int i = 0; i < NUM_PRODUCTS; i++) begin
                            if (sel_hit[i]) stock_d[i] = stock_d[i] - 1'b1;
                        end
                        change_left_d = credit_q - CREDIT_W'(sel_price);
                        credit_d      = '0;
                        disp_id_d     = sel_id_i;
                        state_d       = StDispense;
                    end
                end else if (coin_valid_i) begin
                    if (coin_i == 2'b00 || coin_sum > MaxCreditExt) coin_reject_d = 1'b1;
                    else credit_d = coin_sum[CREDIT_W-1:0];
                end
            end
            StDispense: begin
                coin_reject_d = coin_valid_i;
                state_d       = (change_left_q != '0) ? StChange : StCollect;
            end
            StChange: begin
                coin_reject_d = coin_valid_i;
                if (change_left_q == '0) begin
                    state_d = StCollect;
                end else if (change_ready_i) begin
                    change_left_d = change_left_q - 1'b1;
                    if (change_left_q == CREDIT_W'(1)) state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // Outputs: decoded from registered state only
    always_comb begin
        credit_o       = credit_q;
        dispense_o     = (state_q == StDispense);
        dispense_id_o  = (state_q == StDispense) ? disp_id_q : 3'd0;
        coin_reject_o  = coin_reject_q;
        sel_reject_o   = sel_reject_q;
        change_valid_o = (state_q == StChange) && (change_left_q != '0);
        busy_o         = (state_q != StCollect);
        sold_out_o     = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) sold_out_o[i] = (stock_q[i] == '0);
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with default parameters.
// Prices by slice: product0=3, product1=2, product2=3, product3=4 units.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid, sel_valid, cancel, restock, change_ready;
    logic [1:0] coin_in;
    logic [2:0] sel_id;
    logic [5:0] credit;
    logic       dispense, coin_reject, sel_reject, change_valid, busy;
    logic [2:0] dispense_id;
    logic [3:0] sold_out;

    int n_checks = 0;
    int n_pass   = 0;

    vending_machine_multi dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid_i   (coin_valid),
        .coin_i         (coin_in),
        .sel_valid_i    (sel_valid),
        .sel_id_i       (sel_id),
        .cancel_i       (cancel),
        .restock_i      (restock),
        .change_ready_i (change_ready),
        .credit_o       (credit),
        .dispense_o     (dispense),
        .dispense_id_o  (dispense_id),
        .coin_reject_o  (coin_reject),
        .sel_reject_o   (sel_reject),
        .change_valid_o (change_valid),
        .busy_o         (busy),
        .sold_out_o     (sold_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_in    = v;
        cycle();
        coin_valid = 1'b0;
        coin_in    = 2'b00;
    endtask

    task automatic do_select(input logic [2:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        cycle();
        sel_valid = 1'b0;
        sel_id    = 3'd0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
    endtask

    // Runs until idle with the hopper always ready; counts offered units and dispense pulses.
    task automatic drain(output int units, output int disp);
        units = 0;
        disp  = 0;
        change_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            if (change_valid) units++;
            if (dispense) disp++;
            cycle();
        end
        change_ready = 1'b0;
    endtask

    int units, disp, held;

    initial begin
        rst_n = 1'b0;
        {coin_valid, sel_valid, cancel, restock, change_ready} = '0;
        coin_in = 2'b00;
        sel_id  = 3'd0;
        #12;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_dispense", dispense, 0);
        check("rst_change_valid", change_valid, 0);
        check("rst_rejects", {coin_reject, sel_reject}, 0);
        check("rst_sold_out", sold_out, 0);
        rst_n = 1'b1;
        cycle();

        // Exact payment, product 0 (price 3)
        put_coin(2'b01);
        check("exact_credit1", credit, 1);
        put_coin(2'b10);
        check("exact_credit3", credit, 3);
        do_select(3'd0);
        check("exact_dispense", {dispense, dispense_id}, {1'b1, 3'd0});
        check("exact_credit0", credit, 0);
        cycle();
        check("exact_no_change", {change_valid, busy, dispense}, 0);

        // Overpayment, product 1 (price 2): 6 - 2 = 4 change units
        put_coin(2'b11);
        put_coin(2'b11);
        check("over_credit6", credit, 6);
        do_select(3'd1);
        check("over_dispense", {dispense, dispense_id}, {1'b1, 3'd1});
        cycle();
        held = 0;
        for (int k = 0; k < 3; k++) begin
            if (change_valid) held++;
            if (k == 1) coin_valid = 1'b1;
            coin_in = 2'b01;
            cycle();
            coin_valid = 1'b0;
            coin_in    = 2'b00;
        end
        check("over_valid_held", held, 3);
        check("over_busy_coin_reject", coin_reject, 0);
        drain(units, disp);
        check("over_units", units, 4);
        check("over_idle", {busy, credit}, 0);

        // Coin during a busy state is rejected
        do_cancel();
        put_coin(2'b11);
        do_select(3'd1);
        coin_valid = 1'b1;
        coin_in    = 2'b01;
        cycle();
        coin_valid = 1'b0;
        check("busy_coin_reject", coin_reject, 1);
        drain(units, disp);
        check("busy_coin_units", units, 1);

        // Ceiling and invalid coins
        for (int k = 0; k < 6; k++) put_coin(2'b11);
        put_coin(2'b01);
        check("ceil_credit19", credit, 19);
        put_coin(2'b10);
        check("ceil_reject", {coin_reject, credit}, {1'b1, 6'd19});
        put_coin(2'b00);
        check("invalid_reject", {coin_reject, credit}, {1'b1, 6'd19});
        put_coin(2'b01);
        check("ceil_credit20", {coin_reject, credit}, {1'b0, 6'd20});
        cycle();
        check("reject_one_pulse", coin_reject, 0);
        do_cancel();
        drain(units, disp);
        check("cancel20_units", units, 20);

        // Refusals
        put_coin(2'b01);
        do_select(3'd0);
        check("low_credit_reject", {sel_reject, dispense, credit}, {1'b1, 1'b0, 6'd1});
        do_select(3'd5);
        check("bad_id_reject", {sel_reject, busy}, {1'b1, 1'b0});
        cycle();
        check("sel_reject_pulse", sel_reject, 0);
        do_cancel();
        drain(units, disp);
        check("cancel1_units", units, 1);

        // Product 0 has 9 left after the first sale
        for (int k = 0; k < 9; k++) begin
            put_coin(2'b11);
            do_select(3'd0);
            cycle();
        end
        check("drain_sold_out", sold_out, 4'b0001);
        put_coin(2'b11);
        do_select(3'd0);
        check("sold_out_reject", {sel_reject, credit}, {1'b1, 6'd3});
        restock = 1'b1;
        cycle();
        restock = 1'b0;
        check("restock_sold_out", sold_out, 0);
        do_select(3'd0);
        check("after_restock_dispense", dispense, 1);
        cycle();

        // cancel + select + coin with credit 4
        put_coin(2'b11);
        put_coin(2'b01);
        cancel = 1'b1; sel_valid = 1'b1; sel_id = 3'd1; coin_valid = 1'b1; coin_in = 2'b01;
        cycle();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_in = 2'b00;
        check("simul_cancel", {coin_reject, sel_reject, dispense, credit}, {1'b1, 1'b0, 1'b0, 6'd0});
        drain(units, disp);
        check("simul_cancel_units", units, 4);
        check("simul_cancel_nodisp", disp, 0);

        // select + coin
        put_coin(2'b11);
        sel_valid = 1'b1; sel_id = 3'd2; coin_valid = 1'b1; coin_in = 2'b01;
        cycle();
        sel_valid = 1'b0; coin_valid = 1'b0; coin_in = 2'b00;
        check("simul_sel_coin", {dispense, dispense_id, coin_reject}, {1'b1, 3'd2, 1'b1});
        check("simul_sel_credit", credit, 0);
        cycle();
        check("simul_sel_idle", {busy, change_valid}, 0);

        // Reset during CHANGE with 3 units owed
        put_coin(2'b11);
        do_cancel();
        check("pre_reset_change", change_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("reset_async", {change_valid, busy, dispense, coin_reject, sel_reject, credit}, 0);
        rst_n = 1'b1;
        cycle();
        check("post_reset_idle", {busy, credit, sold_out}, 0);
        // Stock must be back to 10: nine sales leave it in stock, the tenth empties it
        for (int k = 0; k < 10; k++) begin
            if (k == 9) check("post_reset_stock9", sold_out, 0);
            put_coin(2'b11);
            do_select(3'd0);
            cycle();
        end
        check("post_reset_stock10", sold_out, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
